// File: rtl/seq_taillight_ctrl_if.sv
// rtl/seq_taillight_ctrl_if.sv - request inputs and lamp outputs of the taillight controller
interface seq_taillight_ctrl_if #(
  parameter int N_LEDS = 3
);
  logic              left_req;
  logic              right_req;
  logic              hazard_req;
  logic              brake;
  logic [N_LEDS-1:0] led_left;
  logic [N_LEDS-1:0] led_right;
  logic              active;

  modport master (
    output left_req, right_req, hazard_req, brake,
    input  led_left, led_right, active
  );

  modport slave (
    input  left_req, right_req, hazard_req, brake,
    output led_left, led_right, active
  );
endinterface

// File: rtl/seq_taillight_ctrl.sv
// rtl/seq_taillight_ctrl.sv - two-side sequential taillight controller with hazard and brake overlay
module seq_taillight_ctrl #(
  parameter int N_LEDS   = 3,
  parameter int TICK_DIV = 12500000
) (
  input logic             in_clock,
  input logic             reset,
  seq_taillight_ctrl_if.slave lamp
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(N_LEDS + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_LEDS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} mode_t;

  logic [PW-1:0]     prescaler;
  logic              tick;
  mode_t             mode, mode_nxt, req_mode;
  logic [CW-1:0]     count, count_nxt;
  logic [N_LEDS-1:0] seq, brake_mask, left_d, right_d;
  logic              active_d;

  assign tick = (prescaler == PS_LAST);

  always_ff @(posedge in_clock or posedge reset) begin
    if (reset) begin
      prescaler      <= '0;
      mode           <= IDLE;
      count          <= '0;
      lamp.led_left  <= '0;
      lamp.led_right <= '0;
      lamp.active    <= 1'b0;
    end else begin
      prescaler      <= tick ? '0 : prescaler + PW'(1);
      mode           <= mode_nxt;
      count          <= count_nxt;
      lamp.led_left  <= left_d;
      lamp.led_right <= right_d;
      lamp.active    <= active_d;
    end
  end

  // Requests are only sampled at a sequence boundary so a started sweep always completes.
  always_comb begin
    req_mode  = IDLE;
    if (lamp.hazard_req || (lamp.left_req && lamp.right_req)) req_mode = HAZARD;
    else if (lamp.left_req)                                   req_mode = LEFT;
    else if (lamp.right_req)                                  req_mode = RIGHT;

    mode_nxt  = mode;
    count_nxt = count;
    if (tick) begin
      if (count == '0) begin
        mode_nxt  = req_mode;
        count_nxt = (req_mode != IDLE) ? CNT_ONE : '0;
      end else begin
        count_nxt = (count == CNT_LAST) ? '0 : count + CNT_ONE;
      end
    end
  end

  // Outputs follow next-state mode/count so lamps change on the same edge as the count.
  always_comb begin
    seq        = ~({N_LEDS{1'b1}} << count_nxt);
    brake_mask = {N_LEDS{lamp.brake}};
    active_d   = (mode_nxt != IDLE);
    left_d     = brake_mask;
    right_d    = brake_mask;
    case (mode_nxt)
      LEFT:    left_d  = seq;
      RIGHT:   right_d = seq;
      HAZARD: begin
        left_d  = seq;
        right_d = seq;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_seq_taillight_ctrl.sv
// tb/tb_seq_taillight_ctrl.sv - directed self-checking bench for seq_taillight_ctrl
module tb_seq_taillight_ctrl;
  logic in_clock = 1'b0;
  logic reset    = 1'b1;
  logic reset_b  = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  int   e        = 0;

  always #5 in_clock = ~in_clock;

  seq_taillight_ctrl_if #(.N_LEDS(3)) bus_a ();
  seq_taillight_ctrl_if #(.N_LEDS(1)) bus_b ();

  seq_taillight_ctrl #(.N_LEDS(3), .TICK_DIV(4)) dut_a (
    .in_clock (in_clock),
    .reset    (reset),
    .lamp     (bus_a)
  );

  seq_taillight_ctrl #(.N_LEDS(1), .TICK_DIV(1)) dut_b (
    .in_clock (in_clock),
    .reset    (reset_b),
    .lamp     (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic l, input logic r, input logic h, input logic b);
    bus_a.left_req   = l;
    bus_a.right_req  = r;
    bus_a.hazard_req = h;
    bus_a.brake      = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge in_clock);
    @(negedge in_clock);
    reset = 1'b0;
    e = 0;
  endtask

  // Advance to 1 time unit after rising edge k counted from reset release.
  task automatic to_edge(input int k);
    while (e < k) begin
      @(posedge in_clock);
      e++;
    end
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] l, input logic [2:0] r, input logic act);
    check({tag, ".left"},   32'(bus_a.led_left),  32'(l));
    check({tag, ".right"},  32'(bus_a.led_right), 32'(r));
    check({tag, ".active"}, 32'(bus_a.active),    32'(act));
  endtask

  initial begin
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus_b.left_req = 1'b1; bus_b.right_req = 1'b0;
    bus_b.hazard_req = 1'b0; bus_b.brake = 1'b0;
    #1;
    chk_a("reset", 3'b000, 3'b000, 1'b0);

    // left sweep
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    to_edge(3);  chk_a("l_e3",  3'b000, 3'b000, 1'b0);
    to_edge(4);  chk_a("l_e4",  3'b001, 3'b000, 1'b1);
    to_edge(8);  chk_a("l_e8",  3'b011, 3'b000, 1'b1);
    to_edge(12); chk_a("l_e12", 3'b111, 3'b000, 1'b1);
    to_edge(16); chk_a("l_e16", 3'b000, 3'b000, 1'b1);
    to_edge(20); chk_a("l_e20", 3'b001, 3'b000, 1'b1);

    // release mid-sweep
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    to_edge(10); set_req(1'b0, 1'b0, 1'b0, 1'b0);
    to_edge(12); chk_a("rel_e12", 3'b111, 3'b000, 1'b1);
    to_edge(16); check("rel_e16.left", 32'(bus_a.led_left), 32'h0);
    to_edge(20); chk_a("rel_e20", 3'b000, 3'b000, 1'b0);
    to_edge(24); chk_a("rel_e24", 3'b000, 3'b000, 1'b0);

    // hazard during left sweep, brake ignored
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    to_edge(6);  set_req(1'b1, 1'b0, 1'b1, 1'b0);
    to_edge(12); chk_a("hz_e12", 3'b111, 3'b000, 1'b1);
    to_edge(16); chk_a("hz_e16", 3'b000, 3'b000, 1'b1);
    to_edge(20); chk_a("hz_e20", 3'b001, 3'b001, 1'b1);
    to_edge(21); set_req(1'b1, 1'b0, 1'b1, 1'b1);
    to_edge(24); chk_a("hz_e24", 3'b011, 3'b011, 1'b1);
    to_edge(28); chk_a("hz_e28", 3'b111, 3'b111, 1'b1);

    // right with brake, then brake alone in IDLE
    set_req(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    to_edge(3);  chk_a("rb_e3",  3'b111, 3'b111, 1'b0);
    to_edge(4);  chk_a("rb_e4",  3'b111, 3'b001, 1'b1);
    to_edge(8);  chk_a("rb_e8",  3'b111, 3'b011, 1'b1);
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    to_edge(12); chk_a("rb_e12", 3'b111, 3'b111, 1'b1);
    to_edge(16); chk_a("rb_e16", 3'b111, 3'b000, 1'b1);
    to_edge(20); chk_a("rb_e20", 3'b111, 3'b111, 1'b0);
    to_edge(21); chk_a("rb_e21", 3'b111, 3'b111, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    to_edge(22); chk_a("rb_e22", 3'b000, 3'b000, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    to_edge(23); chk_a("rb_e23", 3'b111, 3'b111, 1'b0);

    // left+right acts as hazard; async reset mid-sequence
    set_req(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    to_edge(4);  chk_a("lr_e4", 3'b001, 3'b001, 1'b1);
    to_edge(8);  chk_a("lr_e8", 3'b011, 3'b011, 1'b1);
    to_edge(9);
    #2 reset = 1'b1;
    #1 chk_a("async_rst", 3'b000, 3'b000, 1'b0);
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    to_edge(3);  chk_a("rr_e3", 3'b000, 3'b000, 1'b0);
    to_edge(4);  chk_a("rr_e4", 3'b001, 3'b001, 1'b1);

    // TICK_DIV=1, N_LEDS=1
    @(negedge in_clock);
    reset_b = 1'b0;
    @(posedge in_clock); #1 check("n1_e1", 32'(bus_b.led_left), 32'h1);
    check("n1_e1.active", 32'(bus_b.active), 32'h1);
    @(posedge in_clock); #1 check("n1_e2", 32'(bus_b.led_left), 32'h0);
    @(posedge in_clock); #1 check("n1_e3", 32'(bus_b.led_left), 32'h1);
    @(posedge in_clock); #1 check("n1_e4", 32'(bus_b.led_left), 32'h0);
    check("n1_right", 32'(bus_b.led_right), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
